// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse transceiver: state codes,
// default timing and the command bytes the master FSM sends.
package mouse_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HOLD_CLK  = 4'd1,
        START     = 4'd2,
        DATA      = 4'd3,
        PARITY    = 4'd4,
        STOP      = 4'd5,
        ACK       = 4'd6,
        WAIT_IDLE = 4'd7
    } tx_state_e;

    localparam int T_CLK_HOLD_DEF    = 12000;
    localparam int T_TIMEOUT_DEF     = 100000;
    localparam int T_REQ_TIMEOUT_DEF = 1500000;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/mouse_transmitter_if.sv
// Byte handshake between the mouse master FSM and the transmitter.
// master: SEND_BYTE/BYTE_TO_SEND out; slave: BYTE_SENT/BYTE_ERROR out.
interface mouse_transmitter_if;

    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       BYTE_ERROR;

    modport master (
        output SEND_BYTE,
        output BYTE_TO_SEND,
        input  BYTE_SENT,
        input  BYTE_ERROR
    );

    modport slave (
        input  SEND_BYTE,
        input  BYTE_TO_SEND,
        output BYTE_SENT,
        output BYTE_ERROR
    );

endinterface

// File: rtl/mouse_transmitter_ps2_edge_sync.sv
// Two-flop synchroniser for a PS/2 line plus a falling-edge pulse.
// Ports: CLK, RESET, LINE_IN (raw pad), LINE_SYNC, FALL (1-cycle).
module ps2_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic LINE_IN,
    output logic LINE_SYNC,
    output logic FALL
);

    logic meta;
    logic prev;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta      <= 1'b0;
            LINE_SYNC <= 1'b0;
            prev      <= 1'b0;
        end else begin
            meta      <= LINE_IN;
            LINE_SYNC <= meta;
            prev      <= LINE_SYNC;
        end
    end

    assign FALL = prev & ~LINE_SYNC;

endmodule

// File: rtl/mouse_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB
// first, odd parity, stop, device ACK. Build option MOUSE_TX_ACK_CHECK_EN
// turns a NACK into BYTE_ERROR. Ports: CLK, RESET, mouse clock/data pad
// in/out/enable, host handshake (slave modport), MSTransmitterState.
module mouse_transmitter
    import mouse_pkg::*;
#(
    parameter int T_CLK_HOLD    = T_CLK_HOLD_DEF,
    parameter int T_TIMEOUT     = T_TIMEOUT_DEF,
    parameter int T_REQ_TIMEOUT = T_REQ_TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CLK_MOUSE_IN,
    output logic                CLK_MOUSE_OUT_EN,
    input  logic                DATA_MOUSE_IN,
    output logic                DATA_MOUSE_OUT,
    output logic                DATA_MOUSE_OUT_EN,
    mouse_transmitter_if.slave  host,
    output logic [3:0]          MSTransmitterState
);

    localparam int MAX_A  = (T_TIMEOUT > T_CLK_HOLD) ? T_TIMEOUT : T_CLK_HOLD;
    localparam int WD_MAX = (T_REQ_TIMEOUT > MAX_A) ? T_REQ_TIMEOUT : MAX_A;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    tx_state_e   state;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic [2:0]  bit_cnt;
    logic [WD_W-1:0] wd;
    logic        clk_en;
    logic        data_out;
    logic        data_en;
    logic        sent;
    logic        err;

    logic        clk_sync;
    logic        fe;
    logic        data_meta;
    logic        data_sync;

    logic        hold_done;
    logic        tmo_req;
    logic        tmo_bit;
    logic        abort_now;

    ps2_edge_sync u_clk_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .LINE_IN   (CLK_MOUSE_IN),
        .LINE_SYNC (clk_sync),
        .FALL      (fe)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            data_meta <= DATA_MOUSE_IN;
            data_sync <= data_meta;
        end
    end

    assign hold_done = (wd == WD_W'(T_CLK_HOLD - 1));
    assign tmo_req   = (wd == WD_W'(T_REQ_TIMEOUT - 1));
    assign tmo_bit   = (wd == WD_W'(T_TIMEOUT - 1));

    // Watchdog expiry with no edge this cycle aborts the frame.
    assign abort_now = !fe && (
        (state == START && tmo_req) ||
        ((state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE}) && tmo_bit));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            wd         <= '0;
            clk_en     <= 1'b0;
            data_out   <= 1'b0;
            data_en    <= 1'b0;
            sent       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sent <= 1'b0;
            err  <= 1'b0;
            // Our own clock pull-down produces an edge during HOLD_CLK;
            // it must not restart the hold count.
            if (fe && state != IDLE && state != HOLD_CLK) begin
                wd <= '0;
            end else begin
                wd <= wd + 1'b1;
            end

            if (abort_now) begin
                state    <= IDLE;
                wd       <= '0;
                clk_en   <= 1'b0;
                data_en  <= 1'b0;
                data_out <= 1'b0;
                err      <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        wd       <= '0;
                        clk_en   <= 1'b0;
                        data_en  <= 1'b0;
                        data_out <= 1'b0;
                        if (host.SEND_BYTE) begin
                            shift_reg  <= host.BYTE_TO_SEND;
                            parity_bit <= odd_parity(host.BYTE_TO_SEND);
                            bit_cnt    <= '0;
                            clk_en     <= 1'b1;
                            state      <= HOLD_CLK;
                        end
                    end
                    HOLD_CLK: begin
                        if (hold_done) begin
                            wd       <= '0;
                            data_en  <= 1'b1;
                            data_out <= 1'b0;
                            state    <= START;
                        end
                    end
                    START: begin
                        // Clock stays low one cycle past the start bit.
                        clk_en <= 1'b0;
                        if (fe) begin
                            data_out  <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_cnt   <= '0;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (fe) begin
                            if (bit_cnt == 3'd7) begin
                                data_out <= parity_bit;
                                state    <= PARITY;
                            end else begin
                                data_out  <= shift_reg[0];
                                shift_reg <= {1'b0, shift_reg[7:1]};
                                bit_cnt   <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (fe) begin
                            data_en  <= 1'b0;
                            data_out <= 1'b0;
                            state    <= STOP;
                        end
                    end
                    STOP: begin
                        if (fe) begin
                            state <= ACK;
                        end
                    end
                    ACK: begin
                        if (fe) begin
`ifdef MOUSE_TX_ACK_CHECK_EN
                            if (data_sync) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= WAIT_IDLE;
                            end
`else
                            state <= WAIT_IDLE;
`endif
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            sent  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        clk_en   <= 1'b0;
                        data_en  <= 1'b0;
                        data_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CLK_MOUSE_OUT_EN   = clk_en;
    assign DATA_MOUSE_OUT     = data_out;
    assign DATA_MOUSE_OUT_EN  = data_en;
    assign host.BYTE_SENT     = sent;
    assign host.BYTE_ERROR    = err;
    assign MSTransmitterState = state;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: open-drain bus model plus a mouse that
// clocks frames, samples bits on rising edges and ACKs or NACKs.
module tb_mouse_transmitter;
    import mouse_pkg::*;

    localparam int HOLD = 120;
    localparam int TO   = 1000;
    localparam int REQ  = 1500;

`ifdef MOUSE_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        bit         ack;
        int         np;
        int         half;
        int         inj;
        int         rst_at;
        bit         par;
        bit         sent;
        bit         err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mclk = 1'b1;
    logic mdat = 1'b1;
    logic clk_en, dat_o, dat_en;
    logic [3:0] st;
    logic clk_line, dat_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cyc = 0;
    int tot_sent = 0;
    int tot_err = 0;
    int tot_both = 0;
    int last_err_cyc = 0;

    vec_t tbl[9];
    vec_t v;

    mouse_transmitter_if hif();

    assign clk_line = mclk & ~clk_en;
    assign dat_line = mdat & (dat_en ? dat_o : 1'b1);

    mouse_transmitter #(
        .T_CLK_HOLD    (HOLD),
        .T_TIMEOUT     (TO),
        .T_REQ_TIMEOUT (REQ)
    ) dut (
        .CLK                (clk),
        .RESET              (rst),
        .CLK_MOUSE_IN       (clk_line),
        .CLK_MOUSE_OUT_EN   (clk_en),
        .DATA_MOUSE_IN      (dat_line),
        .DATA_MOUSE_OUT     (dat_o),
        .DATA_MOUSE_OUT_EN  (dat_en),
        .host               (hif),
        .MSTransmitterState (st)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hif.BYTE_SENT === 1'b1) tot_sent++;
        if (hif.BYTE_ERROR === 1'b1) begin
            tot_err++;
            last_err_cyc = cyc;
        end
        if (hif.BYTE_SENT === 1'b1 && hif.BYTE_ERROR === 1'b1) tot_both++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: total ones over data+parity must be odd.
    function automatic bit ref_parity(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic run_tx(input vec_t t);
        int cnt, s0, e0, b0, lat, win;
        bit aborted;
        bit smp;
        bit frame[10];
        for (int i = 0; i < 8; i++) frame[i] = t.b[i];
        frame[8] = t.par;
        frame[9] = 1'b1;
        s0 = tot_sent;
        e0 = tot_err;
        b0 = tot_both;
        aborted = 1'b0;
        hif.BYTE_TO_SEND = t.b;
        hif.SEND_BYTE = 1'b1;
        @(negedge clk);
        hif.SEND_BYTE = 1'b0;
        cnt = 0;
        while (clk_en === 1'b1 && cnt < 4 * HOLD) begin
            cnt++;
            @(negedge clk);
        end
        check("hold_len", cnt, HOLD + 1);
        check("start_bit", dat_line, 0);
        check("start_state", st, START);
        fe_cyc = cyc;
        repeat (20) @(negedge clk);
        for (int p = 1; p <= t.np; p++) begin
            mclk = 1'b0;
            fe_cyc = cyc;
            for (int k = 0; k < t.half; k++) begin
                hif.SEND_BYTE = (t.inj == p && k == 8);
                if (t.inj == p && k == 8) begin
                    hif.BYTE_TO_SEND = 8'h00;
                    check("busy_state", st, DATA);
                end
                if (t.rst_at == p && k == 10) begin
                    check("rst_in_parity", st, PARITY);
                    #2 rst = 1'b1;
                    #1;
                    check("rst_clk_en", clk_en, 0);
                    check("rst_dat_en", dat_en, 0);
                    check("rst_dat_o", dat_o, 0);
                    check("rst_state", st, IDLE);
                    @(negedge clk);
                    rst = 1'b0;
                    aborted = 1'b1;
                end
                @(negedge clk);
            end
            if (aborted) begin
                mclk = 1'b1;
                break;
            end
            smp = dat_line;
            if (p <= 10) check($sformatf("frame%0d", p - 1), smp, frame[p-1]);
            mclk = 1'b1;
            mdat = (p == 10 || p == 11) ? ~t.ack : 1'b1;
            repeat (t.half) @(negedge clk);
        end
        mdat = 1'b1;
        win = (t.np == 0) ? REQ + 100 : ((t.np < 12) ? TO + 100 : 100);
        repeat (win) @(negedge clk);
        check("sent_pulses", tot_sent - s0, t.sent);
        check("err_pulses", tot_err - e0, t.err);
        check("sent_err_excl", tot_both - b0, 0);
        check("end_clk_en", clk_en, 0);
        check("end_dat_en", dat_en, 0);
        check("end_state", st, IDLE);
        if (t.err && t.rst_at == 0 && t.np < 12) begin
            lat = last_err_cyc - fe_cyc;
            if (t.np == 0) check("req_tmo_lat", lat >= REQ - 3 && lat <= REQ + 3, 1);
            else check("bit_tmo_lat", lat >= TO && lat <= TO + 4, 1);
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        hif.SEND_BYTE = 1'b0;
        hif.BYTE_TO_SEND = 8'h00;
        //               b           ack   np  hf  inj rst par   sent      err
        tbl[0] = '{CMD_ENABLE, 1'b1, 12, 40, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{CMD_RESET,  1'b1, 12, 40, 0, 0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{CMD_ENABLE, 1'b1,  4, 40, 0, 0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{CMD_ENABLE, 1'b0, 12, 40, 0, 0, 1'b0, ~ACK_CHK, ACK_CHK};
        tbl[4] = '{CMD_ENABLE, 1'b1, 12, 40, 4, 0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{CMD_ENABLE, 1'b1, 12, 40, 0, 9, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{CMD_ENABLE, 1'b1, 12, 40, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h3C,      1'b1,  0, 40, 0, 0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{8'hA5,      1'b1, 12, 33, 0, 0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_state", st, IDLE);
        check("reset_clk_en", clk_en, 0);
        check("reset_dat_en", dat_en, 0);
        check("reset_dat_o", dat_o, 0);
        check("reset_sent", hif.BYTE_SENT, 0);
        check("reset_err", hif.BYTE_ERROR, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) run_tx(tbl[i]);

        for (int r = 0; r < 6; r++) begin
            v.b = 8'($urandom_range(0, 255));
            v.ack = 1'($urandom_range(0, 1));
            v.np = 12;
            v.half = int'($urandom_range(30, 50));
            v.inj = 0;
            v.rst_at = 0;
            v.par = ref_parity(v.b);
            v.sent = v.ack || !ACK_CHK;
            v.err = !v.sent;
            run_tx(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
